pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_ras.sv | 63 ++++++
 rtl/pc_gen.sv | 91 +++++++++
 tb/tb_pc_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_TRAP   = 2'b11
  } pcsrc_t;

  localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer of RAS_DEPTH entries with saturating
// occupancy; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  // ptr_q is the next write slot; the top of stack sits one below it
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is never reset: contents are unobservable while empty.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[ptr_q] <= push_data;
  end

  assign top   = mem_q[ptr_q - PTR_W'(1)];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC selection (trap, branch, jalr, predicted
// return, sequential) and the PC register; call/return history lives in pc_ras.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(TRAP_VECTOR_DEFAULT),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] RegOp,
  input  logic             call,
  input  logic             ret_pred,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop, ras_clear;
  pcsrc_t           src;

  assign src      = pcsrc_t'(PCsrc);
  assign pc_plus4 = pc_q + WIDTH'(4);

  // Redirects ignore stall; push and pop are mutually exclusive by construction.
  always_comb begin
    pc_d      = pc_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    unique case (src)
      PC_TRAP: begin
        pc_d      = TRAP_VECTOR;
        ras_clear = 1'b1;
      end
      PC_BRANCH: begin
        pc_d     = pc_q + ImmOp;
        ras_push = call;
      end
      PC_JALR: begin
        pc_d     = (RegOp + ImmOp) & ~WIDTH'(1);
        ras_push = call;
      end
      default: begin
        if (!stall) begin
          if (ret_pred && !ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_d;
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign misaligned = |pc_d[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen with a scoreboard queue of expected PC/RAS state.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic [31:0] ImmOp = '0;
  logic [31:0] RegOp = '0;
  logic        call = 1'b0;
  logic        ret_pred = 1'b0;
  logic [31:0] PC, PCPlus4;
  logic        ras_empty, ras_full, misaligned;

  int errors = 0;
  int checks = 0;

  pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .RegOp      (RegOp),
    .call       (call),
    .ret_pred   (ret_pred),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] regop;
    logic        call;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        empty;
    logic        full;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JR = 2'b10, TR = 2'b11;

  function automatic vec_t mk(logic st, logic [1:0] s, logic [31:0] imm, logic [31:0] rg,
                              logic cl, logic rt, logic [31:0] pc, logic e, logic f, logic m);
    vec_t v;
    v.stall = st; v.src = s; v.imm = imm; v.regop = rg; v.call = cl; v.ret = rt;
    v.exp_pc = pc; v.exp_empty = e; v.exp_full = f; v.exp_mis = m;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;

    //          stall src  imm           reg           call ret  pc            emp full mis
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 0, 32'h4,        1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 0, 32'hC,        1, 0, 0));
    vecs.push_back(mk(0, BR,  32'h4,        32'h0,        0, 0, 32'h10,       1, 0, 0));
    vecs.push_back(mk(0, BR,  32'hFFFF_FFF8,32'h0,        0, 0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(0, BR,  32'h8,        32'h0,        0, 0, 32'h10,       1, 0, 0));
    vecs.push_back(mk(1, BR,  32'hFFFF_FFF8,32'h0,        0, 0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(1, SEQ, 32'h0,        32'h0,        0, 0, 32'h8,        1, 0, 0));
    vecs.push_back(mk(1, SEQ, 32'h0,        32'h0,        0, 1, 32'h8,        1, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h20,       0, 0, 32'h20,       1, 0, 0));
    vecs.push_back(mk(0, JR,  32'h4,        32'h101,      1, 0, 32'h104,      0, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 0, 32'h108,      0, 0, 0));
    vecs.push_back(mk(1, SEQ, 32'h0,        32'h0,        0, 1, 32'h108,      0, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h24,       1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h28,       1, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h0,        0, 0, 32'h0,        1, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h10,       1, 0, 32'h10,       0, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h20,       1, 0, 32'h20,       0, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h30,       1, 0, 32'h30,       0, 0, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h40,       1, 0, 32'h40,       0, 1, 0));
    vecs.push_back(mk(0, JR,  32'h0,        32'h1000,     1, 0, 32'h1000,     0, 1, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h44,       0, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h34,       0, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h24,       0, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h14,       1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h18,       1, 0, 0));
    vecs.push_back(mk(0, BR,  32'h0,        32'h0,        1, 0, 32'h18,       0, 0, 0));
    vecs.push_back(mk(0, BR,  32'h8,        32'h0,        1, 0, 32'h20,       0, 0, 0));
    vecs.push_back(mk(1, TR,  32'h0,        32'h0,        0, 0, 32'h100,      1, 0, 0));
    vecs.push_back(mk(0, BR,  32'hFFFF_FF04,32'h0,        0, 0, 32'h4,        1, 0, 0));
    vecs.push_back(mk(0, JR,  32'h4,        32'hFFFF_FFFF,0, 0, 32'h2,        1, 0, 1));
    vecs.push_back(mk(0, BR,  32'h2,        32'h0,        0, 0, 32'h4,        1, 0, 0));
    vecs.push_back(mk(0, TR,  32'h0,        32'h0,        1, 0, 32'h100,      1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        0, 1, 32'h104,      1, 0, 0));
    vecs.push_back(mk(0, SEQ, 32'h0,        32'h0,        1, 0, 32'h108,      1, 0, 0));

    // Reset state
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_pc", PC, 32'h0);
    check("rst_empty", 32'(ras_empty), 32'h1);
    check("rst_full", 32'(ras_full), 32'h0);
    check("rst_pcplus4", PCPlus4, 32'h4);
    @(negedge clk);
    stall = 1'b1;
    rst   = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      stall = vecs[i].stall; PCsrc = vecs[i].src; ImmOp = vecs[i].imm;
      RegOp = vecs[i].regop; call = vecs[i].call; ret_pred = vecs[i].ret;
      #1;
      check($sformatf("v%0d_mis", i), 32'(misaligned), 32'(vecs[i].exp_mis));
      e.idx = i; e.pc = vecs[i].exp_pc; e.empty = vecs[i].exp_empty; e.full = vecs[i].exp_full;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_pc", e.idx), PC, e.pc);
      check($sformatf("v%0d_pcplus4", e.idx), PCPlus4, e.pc + 32'h4);
      check($sformatf("v%0d_empty", e.idx), 32'(ras_empty), 32'(e.empty));
      check($sformatf("v%0d_full", e.idx), 32'(ras_full), 32'(e.full));
    end

    // Mid-cycle asynchronous reset overrides a pending redirect
    @(negedge clk);
    stall = 1'b0; PCsrc = JR; RegOp = 32'h40; ImmOp = 32'h0; call = 1'b1; ret_pred = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_pc", PC, 32'h40);
    check("pre_rst_empty", 32'(ras_empty), 32'h0);
    @(negedge clk);
    PCsrc = BR; ImmOp = 32'h8; call = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", PC, 32'h0);
    check("async_rst_empty", 32'(ras_empty), 32'h1);
    check("async_rst_pcplus4", PCPlus4, 32'h4);
    @(posedge clk); #1;
    check("rst_hold_pc", PC, 32'h0);
    @(negedge clk);
    rst = 1'b0; PCsrc = BR; ImmOp = 32'h2;
    #1;
    check("mis_branch", 32'(misaligned), 32'h1);
    @(posedge clk); #1;
    check("mis_branch_pc", PC, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
